// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern driver:
//   - led_mode_t : 2-bit pattern mode (one-hot, bar, chase, blink)
//   - LED_MAX    : widest LED bank supported by the decode function
//   - led_decode : pure function mapping (mode, pos, phase, count) to the
//                  LED vector; bits at and above 'count' are always zero.
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        LED_MODE_ONEHOT = 2'd0,
        LED_MODE_BAR    = 2'd1,
        LED_MODE_CHASE  = 2'd2,
        LED_MODE_BLINK  = 2'd3
    } led_mode_t;

    localparam int LED_MAX = 64;

    function automatic logic [LED_MAX-1:0] led_decode(
        input led_mode_t  mode,
        input logic [5:0] pos,
        input logic       phase,
        input int         count
    );
        logic [LED_MAX-1:0] v;
        // NOTE: every bit gets a value before any conditional assignment, so
        // the decode stays purely combinational wherever it is used.
        v = '0;
        for (int i = 0; i < LED_MAX; i++) begin
            if (i < count) begin
                case (mode)
                    LED_MODE_ONEHOT,
                    LED_MODE_CHASE:  v[i] = (i == int'(pos));
                    LED_MODE_BAR:    v[i] = (i <= int'(pos));
                    LED_MODE_BLINK:  v[i] = phase && (i == int'(pos));
                    default:         v[i] = 1'b0;
                endcase
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Animation prescaler. Counts enabled cycles 0 .. g_Tick_Div-1 and wraps;
// o_Tick is a combinational strobe that is high in the cycle whose closing
// edge is the wrap edge, so the consumer acts on the tick at that same edge.
//   i_Clk    : system clock
//   i_Rst_n  : asynchronous active-low reset
//   i_Clear  : restart the count at 0 and suppress the tick on this edge
//   i_Enable : count advances only while high; the count holds otherwise
//   o_Tick   : tick strobe (combinational, registered by the parent)
// -----------------------------------------------------------------------------
module led_tick_gen #(
    parameter int g_Tick_Div = 25_000_000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Tick
);

    localparam int              CNT_W = (g_Tick_Div > 2) ? $clog2(g_Tick_Div) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(g_Tick_Div - 1);

    logic [CNT_W-1:0] r_Count;

    // Clear has priority, which is what makes a load beat a coincident tick.
    assign o_Tick = i_Enable && !i_Clear && (r_Count == LAST);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Count <= '0;
        end else if (i_Clear) begin
            r_Count <= '0;
        end else if (i_Enable) begin
            if (r_Count == LAST) r_Count <= '0;
            else                 r_Count <= r_Count + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_driver.sv
// -----------------------------------------------------------------------------
// led_pattern_driver
// Drives a bank of g_LED_Count LEDs with one-hot, bar-graph, chase or blink
// patterns selected by a loaded mode and index. Chase and blink animate on
// a prescaled tick from led_tick_gen. All outputs are registered.
//   i_Clk       : system clock
//   i_Rst_n     : asynchronous active-low reset
//   i_Load      : latch i_Mode / i_LED_Value and restart the prescaler
//   i_Mode      : 0 one-hot, 1 bar, 2 chase, 3 blink
//   i_LED_Value : LED index (saturated to g_LED_Count-1)
//   i_Enable    : runs the prescaler; low freezes all animation
//   o_LED       : LED drive, active-high
//   o_Tick      : one-cycle pulse per animation tick
// -----------------------------------------------------------------------------
module led_pattern_driver
    import led_pkg::*;
#(
    parameter  int g_LED_Count = 16,
    parameter  int g_Tick_Div  = 25_000_000,
    localparam int IDX_W       = $clog2(g_LED_Count)
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_Load,
    input  logic [1:0]             i_Mode,
    input  logic [IDX_W-1:0]       i_LED_Value,
    input  logic                   i_Enable,
    output logic [g_LED_Count-1:0] o_LED,
    output logic                   o_Tick
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(g_LED_Count - 1);

    led_mode_t        r_Mode;
    logic [IDX_W-1:0] r_Pos;
    logic             r_Phase;
    logic             r_Loaded;
    logic             tick_evt;

    // Holding the prescaler cleared until the first load guarantees no tick
    // (and no animation) before a pattern has been selected.
    led_tick_gen #(
        .g_Tick_Div (g_Tick_Div)
    ) u_tick (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Clear  (i_Load || !r_Loaded),
        .i_Enable (i_Enable),
        .o_Tick   (tick_evt)
    );

    // NOTE: every register, outputs included, is cleared by the async reset
    // so o_LED and o_Tick go low immediately, not at the next edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Mode   <= LED_MODE_ONEHOT;
            r_Pos    <= '0;
            r_Phase  <= 1'b0;
            r_Loaded <= 1'b0;
            o_LED    <= '0;
            o_Tick   <= 1'b0;
        end else begin
            o_Tick <= tick_evt;
            o_LED  <= r_Loaded
                    ? g_LED_Count'(led_decode(r_Mode, 6'(r_Pos), r_Phase, g_LED_Count))
                    : '0;

            if (i_Load) begin
                r_Mode   <= led_mode_t'(i_Mode);
                r_Pos    <= (i_LED_Value > LAST_POS) ? LAST_POS : i_LED_Value;
                r_Phase  <= 1'b1;
                r_Loaded <= 1'b1;
            end else if (tick_evt) begin
                case (r_Mode)
                    LED_MODE_CHASE: r_Pos   <= (r_Pos == LAST_POS) ? '0 : r_Pos + 1'b1;
                    LED_MODE_BLINK: r_Phase <= !r_Phase;
                    default:        ;
                endcase
            end
        end
    end

endmodule

// File: doc/led_pattern_driver.md
# led_pattern_driver

Parametrised LED pattern generator driving a bank of `g_LED_Count` board LEDs from a small index value. It supersedes the fixed 4-to-16 one-hot LED decoder and adds bar-graph, chase and blink modes paced by an internal prescaled tick. It sits between control logic (switch or register interface) and the LED pins. All outputs are registered.

## Interface
Parameters:
- `g_LED_Count`, default 16: number of LEDs. Legal range is 2 to 64.
- `g_Tick_Div`, default 25_000_000: clock cycles per animation tick. Must be at least 2. The default gives 4 Hz at 100 MHz.
- `IDX_W` (localparam) = `$clog2(g_LED_Count)`.

Ports:
- `i_Clk` (in, 1): system clock. The block has one clock.
- `i_Rst_n` (in, 1): reset, asynchronous assert, active-low.
- `i_Load` (in, 1): on the same edge, latches `i_Mode` and `i_LED_Value`.
- `i_Mode` (in, 2): 0 = one-hot, 1 = bar, 2 = chase, 3 = blink.
- `i_LED_Value` (in, `IDX_W`): LED index.
- `i_Enable` (in, 1): runs the prescaler. When low, all animation freezes.
- `o_LED` (out, `g_LED_Count`): LED drive, active-high.
- `o_Tick` (out, 1): one-cycle pulse per animation tick.

## Operation
State registers:
- `r_Mode`
- `r_Pos` (`IDX_W`)
- `r_Phase` (blink on/off)
- `r_Loaded`
- prescaler count

Reset (`i_Rst_n` low, any time, mid-animation included):
- All state clears.
- `o_LED` = 0 and `o_Tick` = 0 immediately.
- `r_Loaded` = 0. `o_LED` stays 0 until the first load.

Load:
- `r_Mode` takes `i_Mode`.
- `r_Pos` takes `min(i_LED_Value, g_LED_Count-1)`. Out-of-range indices saturate.
- `r_Phase` = 1.
- Prescaler is cleared to 0.
- `r_Loaded` = 1.

Prescaler:
- While `i_Enable` is high, it counts 0 to `g_Tick_Div-1` and wraps.
- A tick event occurs on the wrap edge.
- While `i_Enable` is low, the count holds and no tick occurs.
- No tick occurs while `r_Loaded` = 0.

Tick action by mode:
- One-hot, bar: no state change.
- Chase: `r_Pos` increments. `g_LED_Count-1` wraps to 0.
- Blink: `r_Phase` toggles.

Simultaneous load and tick:
- Load wins.
- No advance or toggle.
- No `o_Tick` pulse.
- Prescaler restarts at 0.

Output decode (registered):
- One-hot and chase: bit `r_Pos` only.
- Bar: bits 0 through `r_Pos` inclusive.
- Blink: bit `r_Pos` when `r_Phase` = 1, else all zero.
- Not loaded: 0.

Changes to `i_Mode` or `i_LED_Value` without `i_Load` have no effect.

## Timing
- `i_Load` sampled at edge N: state updates at N, and `o_LED` shows the new pattern after edge N+1. Load-to-output latency is 2 edges.
- Tick at edge T: `o_Tick` is high for exactly the cycle between T and T+1, and `o_LED` shows the advanced pattern after T+1.
- Tick period is exactly `g_Tick_Div` cycles of enabled time.
  - The first tick after a load comes `g_Tick_Div` enabled cycles after the load edge.
  - Disabled cycles stretch the period and do not reset it.
- Reset release: the first rising edge after `i_Rst_n` goes high is a normal edge, and `i_Load` may be accepted on it.

## Structure
- Package `led_pkg` holds:
  - the 2-bit mode type and constants `LED_MODE_ONEHOT`, `LED_MODE_BAR`, `LED_MODE_CHASE`, `LED_MODE_BLINK`;
  - a pure decode function (mode, pos, phase, count) returning the LED vector, shared with the bench's reference model.
- Sub-module `led_tick_gen` (parameter `g_Tick_Div`; ports `i_Clk`, `i_Rst_n`, `i_Clear`, `i_Enable`, `o_Tick`) contains the prescaler. The top instantiates it once and registers its pulse onto `o_Tick`.
- Expected size is about 150–250 lines total.

## Test plan
All scenarios use `g_Tick_Div` = 4 and `g_LED_Count` = 16 unless stated.

- Reset, then one-hot load of value 7: `o_LED` = 0 before the load, and `16'h0080` two edges after. Value 0 gives `16'h0001`.
- Bar mode: value 3 gives `16'h000F`. Value 15 gives `16'hFFFF`. Value 0 gives `16'h0001`.
- Chase from value 14 with enable high: `o_LED` steps `16'h4000` → `16'h8000` → `16'h0001` (wrap). `o_Tick` pulses every 4 cycles, one cycle wide.
- Blink at value 2:
  - `o_LED` sequence `16'h0004` → `16'h0000` → `16'h0004` on successive ticks.
  - Dropping `i_Enable` for 10 cycles freezes both the pattern and the tick. On re-enable, the remaining count resumes.
- Load coincident with a tick in chase mode: no advance and no `o_Tick`, and the next tick arrives 4 cycles later. Asserting `i_Rst_n` low mid-chase drives `o_LED` = 0 before the next clock edge.
- `g_LED_Count` = 10, one-hot load of value 12: the index saturates and `o_LED` = `10'h200`. Chase from there wraps to `10'h001`.
